regfile_scan: RTL and testbench

Sequential reader for the 16 x 16-bit register file. On `start` it walks a contiguous, wrap-around range of register indices on one register-file read port, captures each value, and streams `(index, data)` pairs out over a valid/ready handshake. It sits beside the decode stage and drives the second read-port address while the core is halted. Its consumers are the debug/trace logic and the context-save logic.

---
 rtl/regfile_scan.sv | 168 ++++++++++++++++
 tb/tb_regfile_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan.sv
// regfile_scan
// Walks a contiguous, wrap-around range of register-file indices on one read
// port. Each register is captured and streamed out as an (index, data) pair
// over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin a scan (sampled only while idle)
//   abort        cancel the scan in progress (highest priority)
//   first_reg    first index of the range, sampled with start
//   last_reg     last index of the range (inclusive), sampled with start
//   rf_src_reg   read address to the register-file port (always = ptr)
//   rf_src_data  combinational read data from that port
//   out_valid    out_reg/out_data pair is valid
//   out_ready    consumer accepts the pair
//   out_reg      index of the presented register
//   out_data     value of the presented register
//   busy         high whenever not idle
//   done         one-cycle pulse after the final pair transfers
module regfile_scan #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_src_reg,
  input  logic [DATA_W-1:0] rf_src_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  // One extra bit so a full-file scan count (2**ADDR_W) fits.
  localparam int REM_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W-1:0]   ptr_nx_s;
  logic [REM_W-1:0]    remaining_r;
  logic [REM_W-1:0]    remaining_nx_s;
  logic                out_valid_r;
  logic                out_valid_nx_s;
  logic [ADDR_W-1:0]   out_reg_r;
  logic [ADDR_W-1:0]   out_reg_nx_s;
  logic [DATA_W-1:0]   out_data_r;
  logic [DATA_W-1:0]   out_data_nx_s;
  logic                capture_s;
  logic [ADDR_W-1:0]   span_s;

  // Range length minus one; natural modulo-2**ADDR_W wrap handles last < first.
  assign span_s = last_reg - first_reg;

  // Next-state and datapath update logic.
  always_comb begin
    state_nx_s     = state_r;
    ptr_nx_s       = ptr_r;
    remaining_nx_s = remaining_r;
    out_valid_nx_s = out_valid_r;
    out_reg_nx_s   = out_reg_r;
    out_data_nx_s  = out_data_r;
    capture_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          ptr_nx_s       = first_reg;
          remaining_nx_s = {1'b0, span_s} + {{(REM_W-1){1'b0}}, 1'b1};
          state_nx_s     = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_nx_s     = ST_IDLE;
          out_valid_nx_s = 1'b0;
        end else begin
          capture_s      = 1'b1;
          out_valid_nx_s = 1'b1;
          state_nx_s     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (abort) begin
          // Abort suppresses the transfer that would otherwise happen here.
          state_nx_s     = ST_IDLE;
          out_valid_nx_s = 1'b0;
        end else if (out_ready) begin
          if (remaining_r != {REM_W{1'b0}}) begin
            // Back-to-back: fetch the next register on the transfer edge.
            capture_s  = 1'b1;
            state_nx_s = ST_SEND;
          end else begin
            out_valid_nx_s = 1'b0;
            state_nx_s     = ST_DONE;
          end
        end else begin
          // Stalled: hold the presented pair and the read pointer.
          state_nx_s = ST_SEND;
        end
      end

      ST_DONE: begin
        state_nx_s     = ST_IDLE;
        out_valid_nx_s = 1'b0;
      end

      default: begin
        state_nx_s     = ST_IDLE;
        out_valid_nx_s = 1'b0;
      end
    endcase

    if (capture_s) begin
      out_data_nx_s  = rf_src_data;
      out_reg_nx_s   = ptr_r;
      ptr_nx_s       = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      remaining_nx_s = remaining_r - {{(REM_W-1){1'b0}}, 1'b1};
    end else begin
      out_data_nx_s = out_data_nx_s;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ADDR_W{1'b0}};
      remaining_r <= {REM_W{1'b0}};
      out_valid_r <= 1'b0;
      out_reg_r   <= {ADDR_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      ptr_r       <= ptr_nx_s;
      remaining_r <= remaining_nx_s;
      out_valid_r <= out_valid_nx_s;
      out_reg_r   <= out_reg_nx_s;
      out_data_r  <= out_data_nx_s;
    end
  end

  assign rf_src_reg = ptr_r;
  assign out_valid  = out_valid_r;
  assign out_reg    = out_reg_r;
  assign out_data   = out_data_r;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_regfile_scan.sv
// Self-checking bench for regfile_scan: table-driven scans plus hand-written
// stall, busy-start, write-bypass, abort and reset sequences. A scoreboard
// queue holds expected (index, data) pairs; a negedge monitor pops them.
module tb_regfile_scan;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  first_reg;
  logic [3:0]  last_reg;
  logic [3:0]  rf_src_reg;
  logic [15:0] rf_src_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_reg;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  // Register-file model with a write port and write-through read.
  logic [15:0] regs [16];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int total;
  int bad;
  int xfer_cnt;
  int done_cnt;
  logic [19:0] exp_q [$];

  regfile_scan #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .first_reg   (first_reg),
    .last_reg    (last_reg),
    .rf_src_reg  (rf_src_reg),
    .rf_src_data (rf_src_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_reg     (out_reg),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_src_data = (wr_en && (wr_addr == rf_src_reg)) ? wr_data : regs[rf_src_reg];

  always @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Scoreboard monitor: counts done pulses and checks every transfer.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_xfer", {12'h0, out_reg, out_data}, 32'hFFFFFFFF);
        end else begin
          chk("pair", {12'h0, out_reg, out_data}, {12'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic push_range(input logic [3:0] f, input int n);
    logic [3:0] idx;
    for (int k = 0; k < n; k++) begin
      idx = f + 4'(k);
      exp_q.push_back({idx, regs[idx]});
    end
  endtask

  // Called at posedge+1 while idle; out_ready is held high throughout.
  task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input int n);
    int dc;
    dc = -1;
    xfer_cnt = 0;
    done_cnt = 0;
    push_range(f, n);
    start = 1'b1; first_reg = f; last_reg = l;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_addr", rf_src_reg, f);
    chk("load_valid", out_valid, 0);
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_cycle", dc, n + 2);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("xfer_count", xfer_cnt, n);
    chk("done_count", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    int         n;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int c;
    total = 0; bad = 0; xfer_cnt = 0; done_cnt = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_reg = 4'd0; last_reg = 4'd0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);

    tbl[0] = '{4'd3,  4'd5,  3};
    tbl[1] = '{4'd14, 4'd1,  4};
    tbl[2] = '{4'd0,  4'd15, 16};
    tbl[3] = '{4'd7,  4'd7,  1};
    tbl[4] = '{4'd15, 4'd0,  2};
    tbl[5] = '{4'd9,  4'd8,  16};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_reg", out_reg, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rf_src_reg, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_scan(tbl[t].f, tbl[t].l, tbl[t].n);

    // Stall: out_ready low in cycles 4..6 while pair 2 is presented.
    xfer_cnt = 0; done_cnt = 0;
    push_range(4'd0, 8);
    start = 1'b1; first_reg = 4'd0; last_reg = 4'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_reg", out_reg, 2);
      chk("stall_data", out_data, 16'h1002);
      chk("stall_addr", rf_src_reg, 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    c = 7;
    while (!done && c < 40) begin @(posedge clk); #1; c++; end
    chk("stall_done_cycle", c, 13);
    @(posedge clk); #1;
    chk("stall_xfers", xfer_cnt, 8);
    chk("stall_queue", exp_q.size(), 0);
    chk("stall_done_cnt", done_cnt, 1);

    // Single-register scan with start re-pulsed while busy.
    xfer_cnt = 0; done_cnt = 0;
    push_range(4'd7, 1);
    start = 1'b1; first_reg = 4'd7; last_reg = 4'd7;
    @(posedge clk); #1; first_reg = 4'd0; last_reg = 4'd15;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b0;
    chk("single_done", done, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("single_idle", busy, 0);
    chk("single_xfers", xfer_cnt, 1);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_queue", exp_q.size(), 0);

    // Write bypass: r4 written with 0xBEEF in the cycle it is captured.
    xfer_cnt = 0; done_cnt = 0;
    exp_q.push_back({4'd3, 16'h1003});
    exp_q.push_back({4'd4, 16'hBEEF});
    exp_q.push_back({4'd5, 16'h1005});
    start = 1'b1; first_reg = 4'd3; last_reg = 4'd5;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("bypass_addr", rf_src_reg, 4);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hBEEF;
    @(posedge clk); #1; wr_en = 1'b0;
    c = 3;
    while (!done && c < 40) begin @(posedge clk); #1; c++; end
    chk("bypass_done_cycle", c, 5);
    @(posedge clk); #1;
    chk("bypass_xfers", xfer_cnt, 3);
    chk("bypass_queue", exp_q.size(), 0);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h1004;
    @(posedge clk); #1; wr_en = 1'b0;

    // Abort in SEND: one pair sent in cycle 2, abort in cycle 3.
    xfer_cnt = 0; done_cnt = 0;
    push_range(4'd0, 1);
    start = 1'b1; first_reg = 4'd0; last_reg = 4'd7;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_xfers", xfer_cnt, 1);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_queue", exp_q.size(), 0);

    // Asynchronous reset mid-scan, then a normal scan.
    push_range(4'd0, 16);
    start = 1'b1; first_reg = 4'd0; last_reg = 4'd15;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_reg", out_reg, 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", rf_src_reg, 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_scan(4'd2, 4'd4, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
